// File: rtl/alu_result_fifo.sv
// alu_result_fifo: DEPTH-entry result buffer between the ALU and writeback.
// Stores {word, zero, neg, opcode} unmodified, valid/ready on both sides,
// and keeps saturating statistics of zero/negative results accepted.
module alu_result_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int OPCW  = 3,
   parameter int CNTW  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         inW,
   input  logic                     inZer,
   input  logic                     inNeg,
   input  logic [OPCW-1:0]          inOpc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         outW,
   output logic                     outZer,
   output logic                     outNeg,
   output logic [OPCW-1:0]          outOpc,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNTW-1:0]          zer_cnt,
   output logic [CNTW-1:0]          neg_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]   FULL = CW'(DEPTH);
   localparam logic [CNTW-1:0] CMAX = '1;

   typedef struct packed {
      logic [WIDTH-1:0] w;
      logic             zer;
      logic             neg;
      logic [OPCW-1:0]  opc;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        last_q;
   entry_t        head;
   entry_t        wr_ent;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // Both handshake flags come from the count register only, so in_ready
   // never depends on out_ready (a full FIFO refuses even with a pop).
   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign wr_ent    = '{w: inW, zer: inZer, neg: inNeg, opc: inOpc};

   // Head is the live entry when occupied, otherwise the last entry popped
   // (zero after reset), so the outputs never show stale/unwritten storage.
   always_comb begin
      head = last_q;
      if (count != '0) head = mem[rd_ptr];
   end

   assign outW   = head.w;
   assign outZer = head.zer;
   assign outNeg = head.neg;
   assign outOpc = head.opc;

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_ent;
   end

   // Pointers, occupancy and the popped-entry shadow; flush drops the
   // cycle's push and pop but leaves the shadow untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            last_q <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Saturating statistics; only reset clears them, flush does not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zer_cnt <= '0;
         neg_cnt <= '0;
      end else if (push) begin
         if (inZer && zer_cnt != CMAX) zer_cnt <= zer_cnt + CNTW'(1);
         if (inNeg && neg_cnt != CMAX) neg_cnt <= neg_cnt + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed vectors with literal expectations plus a
// queue-based reference model compared against the DUT every cycle.
module tb_alu_result_fifo;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int OPCW  = 3;
   localparam int CNTW  = 8;

   typedef struct {
      logic [WIDTH-1:0] w;
      logic             z;
      logic             n;
      logic [OPCW-1:0]  o;
   } ent_t;

   logic             clk = 0;
   logic             rst_n = 0;
   logic             flush = 0;
   logic             in_valid = 0;
   logic             in_ready;
   logic [WIDTH-1:0] inW = '0;
   logic             inZer = 0;
   logic             inNeg = 0;
   logic [OPCW-1:0]  inOpc = '0;
   logic             out_valid;
   logic             out_ready = 0;
   logic [WIDTH-1:0] outW;
   logic             outZer;
   logic             outNeg;
   logic [OPCW-1:0]  outOpc;
   logic [2:0]       count;
   logic [CNTW-1:0]  zer_cnt;
   logic [CNTW-1:0]  neg_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   ent_t q[$];
   ent_t lastpop = '{w: '0, z: 0, n: 0, o: '0};
   int   zc = 0;
   int   nc = 0;

   alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPCW(OPCW), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .inW(inW), .inZer(inZer), .inNeg(inNeg), .inOpc(inOpc),
      .out_valid(out_valid), .out_ready(out_ready),
      .outW(outW), .outZer(outZer), .outNeg(outNeg), .outOpc(outOpc),
      .count(count), .zer_cnt(zer_cnt), .neg_cnt(neg_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: FIFO as a queue, statistics as clamped integers
   always @(posedge clk) begin
      if (rst_n) begin
         automatic bit do_push = in_valid && (q.size() != DEPTH) && !flush;
         automatic bit do_pop  = (q.size() != 0) && out_ready && !flush;
         if (flush) q.delete();
         else begin
            if (do_pop) lastpop = q.pop_front();
            if (do_push) q.push_back('{w: inW, z: inZer, n: inNeg, o: inOpc});
         end
         if (do_push) begin
            if (inZer) zc = (zc + 1 > 255) ? 255 : zc + 1;
            if (inNeg) nc = (nc + 1 > 255) ? 255 : nc + 1;
         end
      end
   end

   always @(negedge rst_n) begin
      q.delete();
      lastpop = '{w: '0, z: 0, n: 0, o: '0};
      zc = 0;
      nc = 0;
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         automatic ent_t h = (q.size() != 0) ? q[0] : lastpop;
         chk("m_count",     int'(count),     q.size());
         chk("m_in_ready",  int'(in_ready),  int'(q.size() != DEPTH));
         chk("m_out_valid", int'(out_valid), int'(q.size() != 0));
         chk("m_outW",      int'(outW),      int'(h.w));
         chk("m_outZer",    int'(outZer),    int'(h.z));
         chk("m_outNeg",    int'(outNeg),    int'(h.n));
         chk("m_outOpc",    int'(outOpc),    int'(h.o));
         chk("m_zer_cnt",   int'(zer_cnt),   zc);
         chk("m_neg_cnt",   int'(neg_cnt),   nc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] w,
                        input logic z, input logic n, input logic [OPCW-1:0] o);
      in_valid = v; inW = w; inZer = z; inNeg = n; inOpc = o;
   endtask

   logic [WIDTH-1:0] vec_w [4];
   logic             vec_n [4];

   initial begin
      vec_w[0] = 16'h0001; vec_n[0] = 0;
      vec_w[1] = 16'h8000; vec_n[1] = 1;
      vec_w[2] = 16'h7FFF; vec_n[2] = 0;
      vec_w[3] = 16'hFFFF; vec_n[3] = 1;

      // reset state
      #1;
      chk("rst_count", int'(count), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_outW", int'(outW), 0);
      chk("rst_zer_cnt", int'(zer_cnt), 0);
      #12 rst_n = 1;
      step();

      // single push of a zero result
      drive(1, 16'h0000, 1, 0, 3'd0);
      out_ready = 0;
      step();
      drive(0, '0, 0, 0, '0);
      chk("p1_count", int'(count), 1);
      chk("p1_out_valid", int'(out_valid), 1);
      chk("p1_outW", int'(outW), 0);
      chk("p1_outZer", int'(outZer), 1);
      chk("p1_zer_cnt", int'(zer_cnt), 1);
      out_ready = 1;
      step();
      out_ready = 0;
      chk("p1_drain", int'(count), 0);

      // fill to DEPTH, fifth push refused
      for (int i = 0; i < 4; i++) begin
         drive(1, vec_w[i], 0, vec_n[i], 3'(i + 1));
         step();
      end
      chk("full_count", int'(count), 4);
      chk("full_in_ready", int'(in_ready), 0);
      drive(1, 16'h1234, 1, 1, 3'd7);
      step();
      drive(0, '0, 0, 0, '0);
      chk("drop_count", int'(count), 4);
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         chk("pop_outW", int'(outW), int'(vec_w[i]));
         chk("pop_outNeg", int'(outNeg), int'(vec_n[i]));
         chk("pop_outOpc", int'(outOpc), i + 1);
         step();
      end
      out_ready = 0;
      chk("empty_count", int'(count), 0);
      chk("empty_last_outW", int'(outW), 16'hFFFF);

      // steady push+pop with two entries, pointers wrap
      drive(1, 16'hAAAA, 0, 0, 3'd1); step();
      drive(1, 16'hBBBB, 0, 0, 3'd2); step();
      out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         drive(1, 16'h0100 + 16'(i), 0, 0, 3'(i));
         step();
         chk("stream_count", int'(count), 2);
      end
      out_ready = 0;
      chk("stream_head", int'(outW), 16'h0108);

      // flush at count=3 with push and pop requests
      drive(1, 16'h0200, 0, 0, 3'd3); step();
      chk("pre_flush_count", int'(count), 3);
      drive(1, 16'h0300, 1, 1, 3'd4);
      out_ready = 1;
      flush = 1;
      step();
      flush = 0;
      out_ready = 0;
      drive(0, '0, 0, 0, '0);
      chk("flush_count", int'(count), 0);
      chk("flush_out_valid", int'(out_valid), 0);
      chk("flush_in_ready", int'(in_ready), 1);
      chk("flush_zer_cnt", int'(zer_cnt), 1);
      chk("flush_neg_cnt", int'(neg_cnt), 2);
      chk("flush_last_outW", int'(outW), 16'h0107);

      // statistics saturation
      out_ready = 1;
      for (int i = 0; i < 300; i++) begin
         drive(1, 16'(i), 1, 1, 3'(i));
         step();
      end
      drive(0, '0, 0, 0, '0);
      chk("sat_zer_cnt", int'(zer_cnt), 255);
      chk("sat_neg_cnt", int'(neg_cnt), 255);
      step();
      out_ready = 0;
      chk("sat_drain", int'(count), 0);

      // asynchronous reset between edges
      drive(1, 16'h5555, 1, 0, 3'd5); step();
      drive(1, 16'hC0DE, 0, 1, 3'd6); step();
      drive(0, '0, 0, 0, '0);
      chk("prerst_count", int'(count), 2);
      #2 rst_n = 0;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_in_ready", int'(in_ready), 1);
      chk("arst_outW", int'(outW), 0);
      chk("arst_outZer", int'(outZer), 0);
      chk("arst_outNeg", int'(outNeg), 0);
      chk("arst_zer_cnt", int'(zer_cnt), 0);
      chk("arst_neg_cnt", int'(neg_cnt), 0);
      #4 rst_n = 1;
      step();
      chk("post_rst_count", int'(count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
